// File: rtl/axil_arb2_if.sv
// rtl/axil_arb2_if.sv - AXI-lite signal bundle used for both requester ports and the RAM port
interface axil_arb2_if #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int STRB_WIDTH = DW / 8
);
  logic [AW-1:0]         awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DW-1:0]         wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AW-1:0]         araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  // Side that issues requests
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  // Side that serves requests
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_arb2.sv
// rtl/axil_arb2.sv - two-requester AXI-lite arbiter in front of one shared RAM port
module axil_arb2 #(
  parameter int DW         = 32,
  parameter int AW         = 16,
  parameter int STRB_WIDTH = DW / 8
) (
  input  logic        clk,
  input  logic        rst_n,
  axil_arb2_if.slave  s0_axil,
  axil_arb2_if.slave  s1_axil,
  axil_arb2_if.master m_axil
);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} r_state_t;

  logic [1:0] rst_sync;
  logic       run;

  // Two-stage release of the asynchronous reset; grants wait until it is through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  // ---------------- write path ----------------
  w_state_t              w_state;
  logic                  w_last, w_grant, w_win, w_req0, w_req1, w_sel_bready;
  logic [1:0]            s_awready_q, s_wready_q, s_bvalid_q;
  logic [1:0]            w_bresp_q;
  logic                  m_awvalid_q, m_wvalid_q;
  logic [AW-1:0]         m_awaddr_q;
  logic [2:0]            m_awprot_q;
  logic [DW-1:0]         m_wdata_q;
  logic [STRB_WIDTH-1:0] m_wstrb_q;

  assign w_req0       = s0_axil.awvalid && s0_axil.wvalid;
  assign w_req1       = s1_axil.awvalid && s1_axil.wvalid;
  assign w_win        = (w_req0 && w_req1) ? ~w_last : ~w_req0;
  assign w_sel_bready = w_grant ? s1_axil.bready : s0_axil.bready;
  // Accept the RAM response only in the cycle it is captured
  assign m_axil.bready = (w_state == W_RESP) && (s_bvalid_q == 2'b00) && m_axil.bvalid;

  // Write FSM: grant, forward AW/W independently, relay B to the granted port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state     <= W_IDLE;
      w_last      <= 1'b1;
      w_grant     <= 1'b0;
      s_awready_q <= 2'b00;
      s_wready_q  <= 2'b00;
      s_bvalid_q  <= 2'b00;
      w_bresp_q   <= 2'b00;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_awaddr_q  <= '0;
      m_awprot_q  <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else begin
      s_awready_q <= 2'b00;
      s_wready_q  <= 2'b00;
      case (w_state)
        W_IDLE: begin
          if (run && (w_req0 || w_req1)) begin
            w_grant     <= w_win;
            s_awready_q <= {w_win, ~w_win};
            s_wready_q  <= {w_win, ~w_win};
            m_awaddr_q  <= w_win ? s1_axil.awaddr : s0_axil.awaddr;
            m_awprot_q  <= w_win ? s1_axil.awprot : s0_axil.awprot;
            m_wdata_q   <= w_win ? s1_axil.wdata  : s0_axil.wdata;
            m_wstrb_q   <= w_win ? s1_axil.wstrb  : s0_axil.wstrb;
            m_awvalid_q <= 1'b1;
            m_wvalid_q  <= 1'b1;
            w_state     <= W_FWD;
          end
        end
        W_FWD: begin
          if (m_axil.awready) m_awvalid_q <= 1'b0;
          if (m_axil.wready)  m_wvalid_q  <= 1'b0;
          if ((!m_awvalid_q || m_axil.awready) && (!m_wvalid_q || m_axil.wready))
            w_state <= W_RESP;
        end
        W_RESP: begin
          if (s_bvalid_q != 2'b00) begin
            if (w_sel_bready) begin
              s_bvalid_q <= 2'b00;
              w_last     <= w_grant;
              w_state    <= W_IDLE;
            end
          end else if (m_axil.bvalid) begin
            w_bresp_q  <= m_axil.bresp;
            s_bvalid_q <= {w_grant, ~w_grant};
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_t      r_state;
  logic          r_last, r_grant, r_win, r_sel_rready;
  logic [1:0]    s_arready_q, s_rvalid_q;
  logic [1:0]    r_rresp_q;
  logic [DW-1:0] r_rdata_q;
  logic          m_arvalid_q;
  logic [AW-1:0] m_araddr_q;
  logic [2:0]    m_arprot_q;

  assign r_win        = (s0_axil.arvalid && s1_axil.arvalid) ? ~r_last : ~s0_axil.arvalid;
  assign r_sel_rready = r_grant ? s1_axil.rready : s0_axil.rready;
  assign m_axil.rready = (r_state == R_RESP) && (s_rvalid_q == 2'b00) && m_axil.rvalid;

  // Read FSM: grant, forward AR, relay R to the granted port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= R_IDLE;
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      s_arready_q <= 2'b00;
      s_rvalid_q  <= 2'b00;
      r_rresp_q   <= 2'b00;
      r_rdata_q   <= '0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arprot_q  <= '0;
    end else begin
      s_arready_q <= 2'b00;
      case (r_state)
        R_IDLE: begin
          if (run && (s0_axil.arvalid || s1_axil.arvalid)) begin
            r_grant     <= r_win;
            s_arready_q <= {r_win, ~r_win};
            m_araddr_q  <= r_win ? s1_axil.araddr : s0_axil.araddr;
            m_arprot_q  <= r_win ? s1_axil.arprot : s0_axil.arprot;
            m_arvalid_q <= 1'b1;
            r_state     <= R_FWD;
          end
        end
        R_FWD: begin
          if (m_axil.arready) begin
            m_arvalid_q <= 1'b0;
            r_state     <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rvalid_q != 2'b00) begin
            if (r_sel_rready) begin
              s_rvalid_q <= 2'b00;
              r_last     <= r_grant;
              r_state    <= R_IDLE;
            end
          end else if (m_axil.rvalid) begin
            r_rdata_q  <= m_axil.rdata;
            r_rresp_q  <= m_axil.rresp;
            s_rvalid_q <= {r_grant, ~r_grant};
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign m_axil.awaddr  = m_awaddr_q;
  assign m_axil.awprot  = m_awprot_q;
  assign m_axil.awvalid = m_awvalid_q;
  assign m_axil.wdata   = m_wdata_q;
  assign m_axil.wstrb   = m_wstrb_q;
  assign m_axil.wvalid  = m_wvalid_q;
  assign m_axil.araddr  = m_araddr_q;
  assign m_axil.arprot  = m_arprot_q;
  assign m_axil.arvalid = m_arvalid_q;

  assign s0_axil.awready = s_awready_q[0];
  assign s0_axil.wready  = s_wready_q[0];
  assign s0_axil.bvalid  = s_bvalid_q[0];
  assign s0_axil.bresp   = w_bresp_q;
  assign s0_axil.arready = s_arready_q[0];
  assign s0_axil.rvalid  = s_rvalid_q[0];
  assign s0_axil.rdata   = r_rdata_q;
  assign s0_axil.rresp   = r_rresp_q;

  assign s1_axil.awready = s_awready_q[1];
  assign s1_axil.wready  = s_wready_q[1];
  assign s1_axil.bvalid  = s_bvalid_q[1];
  assign s1_axil.bresp   = w_bresp_q;
  assign s1_axil.arready = s_arready_q[1];
  assign s1_axil.rvalid  = s_rvalid_q[1];
  assign s1_axil.rdata   = r_rdata_q;
  assign s1_axil.rresp   = r_rresp_q;

endmodule

// File: tb/tb_axil_arb2.sv
// tb/tb_axil_arb2.sv - directed self-checking bench for axil_arb2 with a small RAM model
module tb_axil_arb2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_arb2_if #(.DW(DW), .AW(AW), .STRB_WIDTH(SW)) s0_if ();
  axil_arb2_if #(.DW(DW), .AW(AW), .STRB_WIDTH(SW)) s1_if ();
  axil_arb2_if #(.DW(DW), .AW(AW), .STRB_WIDTH(SW)) m_if ();

  axil_arb2 #(.DW(DW), .AW(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .s0_axil(s0_if), .s1_axil(s1_if), .m_axil(m_if)
  );

  // requester-side signals indexed by port
  logic [AW-1:0] awaddr [2];
  logic [DW-1:0] wdata  [2];
  logic [SW-1:0] wstrb  [2];
  logic [AW-1:0] araddr [2];
  logic awvalid [2], wvalid [2], bready [2], arvalid [2], rready [2];
  logic awready [2], wready [2], bvalid [2], arready [2], rvalid [2];
  logic [1:0]    bresp [2], rresp [2];
  logic [DW-1:0] rdata [2];

  assign s0_if.awaddr = awaddr[0];  assign s0_if.awprot = 3'b000; assign s0_if.awvalid = awvalid[0];
  assign s0_if.wdata  = wdata[0];   assign s0_if.wstrb  = wstrb[0]; assign s0_if.wvalid = wvalid[0];
  assign s0_if.bready = bready[0];  assign s0_if.araddr = araddr[0]; assign s0_if.arprot = 3'b000;
  assign s0_if.arvalid = arvalid[0]; assign s0_if.rready = rready[0];
  assign awready[0] = s0_if.awready; assign wready[0] = s0_if.wready; assign bvalid[0] = s0_if.bvalid;
  assign bresp[0] = s0_if.bresp; assign arready[0] = s0_if.arready; assign rvalid[0] = s0_if.rvalid;
  assign rdata[0] = s0_if.rdata; assign rresp[0] = s0_if.rresp;

  assign s1_if.awaddr = awaddr[1];  assign s1_if.awprot = 3'b000; assign s1_if.awvalid = awvalid[1];
  assign s1_if.wdata  = wdata[1];   assign s1_if.wstrb  = wstrb[1]; assign s1_if.wvalid = wvalid[1];
  assign s1_if.bready = bready[1];  assign s1_if.araddr = araddr[1]; assign s1_if.arprot = 3'b000;
  assign s1_if.arvalid = arvalid[1]; assign s1_if.rready = rready[1];
  assign awready[1] = s1_if.awready; assign wready[1] = s1_if.wready; assign bvalid[1] = s1_if.bvalid;
  assign bresp[1] = s1_if.bresp; assign arready[1] = s1_if.arready; assign rvalid[1] = s1_if.rvalid;
  assign rdata[1] = s1_if.rdata; assign rresp[1] = s1_if.rresp;

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [64];
  int            aw_delay = 0;
  int            aw_wait;
  int            ram_writes = 0;
  logic          have_aw, have_w, ram_bvalid, ram_rvalid;
  logic [AW-1:0] ram_awaddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [SW-1:0] ram_wstrb;
  logic [1:0]    ram_bresp, ram_rresp;

  function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
    if (a[15:12] == 4'hE) return 2'b10;
    if (a[15:12] == 4'hF) return 2'b11;
    return 2'b00;
  endfunction

  assign m_if.awready = !have_aw && (aw_wait >= aw_delay);
  assign m_if.wready  = !have_w;
  assign m_if.bvalid  = ram_bvalid;
  assign m_if.bresp   = ram_bresp;
  assign m_if.arready = !ram_rvalid;
  assign m_if.rvalid  = ram_rvalid;
  assign m_if.rdata   = ram_rdata;
  assign m_if.rresp   = ram_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_aw <= 1'b0; have_w <= 1'b0; aw_wait <= 0;
      ram_bvalid <= 1'b0; ram_rvalid <= 1'b0;
      ram_bresp <= 2'b00; ram_rresp <= 2'b00; ram_rdata <= '0;
    end else begin
      if (m_if.awvalid && m_if.awready) begin
        have_aw <= 1'b1; ram_awaddr <= m_if.awaddr; aw_wait <= 0;
      end else if (m_if.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (m_if.wvalid && m_if.wready) begin
        have_w <= 1'b1; ram_wdata <= m_if.wdata; ram_wstrb <= m_if.wstrb;
      end
      if (have_aw && have_w && !ram_bvalid) begin
        for (int i = 0; i < SW; i++)
          if (ram_wstrb[i]) mem[ram_awaddr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
        ram_bvalid <= 1'b1; ram_bresp <= resp_for(ram_awaddr);
        have_aw <= 1'b0; have_w <= 1'b0; ram_writes <= ram_writes + 1;
      end
      if (ram_bvalid && m_if.bready) ram_bvalid <= 1'b0;
      if (m_if.arvalid && m_if.arready) begin
        ram_rvalid <= 1'b1; ram_rdata <= mem[m_if.araddr[7:2]]; ram_rresp <= resp_for(m_if.araddr);
      end else if (ram_rvalid && m_if.rready) begin
        ram_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int awr_hi [2] = '{0, 0};
  int wr_hi  [2] = '{0, 0};
  int ar_hi  [2] = '{0, 0};
  int bv_hi  [2] = '{0, 0};
  int out_hi [2] = '{0, 0};
  int b_hs   [2] = '{0, 0};
  int m_awv_hi = 0, m_wv_hi = 0, gnt_no_fwd = 0;
  int glog [$];
  logic [AW-1:0] last_m_awaddr = '0;

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (awready[p]) begin awr_hi[p] <= awr_hi[p] + 1; glog.push_back(p); end
      if (wready[p])  wr_hi[p] <= wr_hi[p] + 1;
      if (arready[p]) ar_hi[p] <= ar_hi[p] + 1;
      if (bvalid[p])  bv_hi[p] <= bv_hi[p] + 1;
      if (bvalid[p] && bready[p]) b_hs[p] <= b_hs[p] + 1;
      if (awready[p] || wready[p] || bvalid[p] || arready[p] || rvalid[p]) out_hi[p] <= out_hi[p] + 1;
      if (awready[p] && !m_if.awvalid) gnt_no_fwd <= gnt_no_fwd + 1;
    end
    if (m_if.awvalid) m_awv_hi <= m_awv_hi + 1;
    if (m_if.wvalid)  m_wv_hi  <= m_wv_hi + 1;
    if (m_if.awvalid && m_if.awready) last_m_awaddr <= m_if.awaddr;
  end

  // ---------------- bench ----------------
  int errors = 0;
  int checks = 0;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output logic [1:0] resp, output int lat);
    int n;
    resp = 2'bxx;
    awaddr[p] = a; wdata[p] = d; wstrb[p] = s; awvalid[p] = 1'b1; wvalid[p] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready[p] && n < 200);
    lat = n;
    if (!awready[p]) begin
      checks++; errors++;
      $display("FAIL wr_grant_timeout port%0d: awready=%0b required 1", p, awready[p]);
      awvalid[p] = 1'b0; wvalid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid[p] = 1'b0; wvalid[p] = 1'b0; bready[p] = 1'b1;
    n = 0;
    while (!bvalid[p] && n < 200) begin @(posedge clk); #1; n++; end
    if (!bvalid[p]) begin
      checks++; errors++;
      $display("FAIL wr_resp_timeout port%0d: bvalid=%0b required 1", p, bvalid[p]);
      bready[p] = 1'b0;
      return;
    end
    resp = bresp[p];
    @(posedge clk); #1;
    bready[p] = 1'b0;
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    d = 'x; resp = 2'bxx;
    araddr[p] = a; arvalid[p] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready[p] && n < 200);
    lat = n;
    if (!arready[p]) begin
      checks++; errors++;
      $display("FAIL rd_grant_timeout port%0d: arready=%0b required 1", p, arready[p]);
      arvalid[p] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid[p] = 1'b0; rready[p] = 1'b1;
    n = 0;
    while (!rvalid[p] && n < 200) begin @(posedge clk); #1; n++; end
    if (!rvalid[p]) begin
      checks++; errors++;
      $display("FAIL rd_resp_timeout port%0d: rvalid=%0b required 1", p, rvalid[p]);
      rready[p] = 1'b0;
      return;
    end
    d = rdata[p]; resp = rresp[p];
    @(posedge clk); #1;
    rready[p] = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] r; int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready[0], wready[0], bvalid[0], arready[0], rvalid[0],
         awready[1], wready[1], bvalid[1], arready[1], rvalid[1]} !== 10'b0) begin
      errors++; $display("FAIL reset_port_outputs: got %b required 0",
        {awready[0], wready[0], bvalid[0], arready[0], rvalid[0],
         awready[1], wready[1], bvalid[1], arready[1], rvalid[1]});
    end
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_m_outputs: got %b required 0",
        {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready});
    end
    checks++;
    if ({bresp[0], rresp[0], rdata[0], m_if.awaddr, m_if.wdata, m_if.araddr} !== '0) begin
      errors++; $display("FAIL reset_data_regs: got %h required 0",
        {bresp[0], rresp[0], rdata[0], m_if.awaddr, m_if.wdata, m_if.araddr});
    end
    // release with port 0 already requesting
    rst_n = 1'b1;
    do_write(0, 16'h0008, 32'h11223344, 4'h3, r, lat);
    checks++;
    if (lat < 2) begin errors++; $display("FAIL reset_release_grant_edge: got %0d required >=2", lat); end
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL reset_first_bresp: got %b required 00", r); end
    checks++;
    if (mem[2][15:0] !== 16'h3344) begin errors++; $display("FAIL reset_first_strobed_data: got %h required 3344", mem[2][15:0]); end
  endtask

  task automatic test_single_write();
    logic [1:0] r; int lat;
    int a0, w0, o1, b0, g0;
    a0 = awr_hi[0]; w0 = wr_hi[0]; o1 = out_hi[1]; b0 = b_hs[0]; g0 = gnt_no_fwd;
    do_write(0, 16'h0010, 32'hDEADBEEF, 4'hF, r, lat);
    repeat (2) @(posedge clk); #1;
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b required 00", r); end
    checks++; if (awr_hi[0] - a0 != 1) begin errors++; $display("FAIL single_awready_pulses: got %0d required 1", awr_hi[0] - a0); end
    checks++; if (wr_hi[0] - w0 != 1) begin errors++; $display("FAIL single_wready_pulses: got %0d required 1", wr_hi[0] - w0); end
    checks++; if (out_hi[1] - o1 != 0) begin errors++; $display("FAIL single_s1_quiet: got %0d required 0", out_hi[1] - o1); end
    checks++; if (last_m_awaddr !== 16'h0010) begin errors++; $display("FAIL single_m_awaddr: got %h required 0010", last_m_awaddr); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_ram_data: got %h required deadbeef", mem[4]); end
    checks++; if (b_hs[0] - b0 != 1) begin errors++; $display("FAIL single_b_handshakes: got %0d required 1", b_hs[0] - b0); end
    checks++; if (gnt_no_fwd - g0 != 0) begin errors++; $display("FAIL single_grant_to_m_awvalid: got %0d required 0", gnt_no_fwd - g0); end
  endtask

  task automatic test_tie();
    logic [1:0] r0a, r0b, r1a, r1b; int l0, l1; int base, b0, b1;
    int exp_order [4] = '{0, 1, 0, 1};
    do_reset();
    base = glog.size(); b0 = b_hs[0]; b1 = b_hs[1];
    fork
      begin do_write(0, 16'hE000, 32'hA0A0A0A0, 4'hF, r0a, l0); do_write(0, 16'h0060, 32'hA1A1A1A1, 4'hF, r0b, l0); end
      begin do_write(1, 16'hF000, 32'hB0B0B0B0, 4'hF, r1a, l1); do_write(1, 16'h0064, 32'hB1B1B1B1, 4'hF, r1b, l1); end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (glog.size() <= base + i) begin
        errors++; $display("FAIL tie_grant_%0d: got none required port%0d", i, exp_order[i]);
      end else if (glog[base + i] != exp_order[i]) begin
        errors++; $display("FAIL tie_grant_%0d: got port%0d required port%0d", i, glog[base + i], exp_order[i]);
      end
    end
    checks++; if (r0a !== 2'b10) begin errors++; $display("FAIL tie_s0_slverr: got %b required 10", r0a); end
    checks++; if (r1a !== 2'b11) begin errors++; $display("FAIL tie_s1_decerr: got %b required 11", r1a); end
    checks++; if (r0b !== 2'b00 || r1b !== 2'b00) begin errors++; $display("FAIL tie_okay: got %b/%b required 00/00", r0b, r1b); end
    checks++;
    if (b_hs[0] - b0 != 2 || b_hs[1] - b1 != 2) begin
      errors++; $display("FAIL tie_b_routing: got %0d/%0d required 2/2", b_hs[0] - b0, b_hs[1] - b1);
    end
    checks++;
    if (mem[24] !== 32'hA1A1A1A1 || mem[25] !== 32'hB1B1B1B1) begin
      errors++; $display("FAIL tie_ram_data: got %h/%h required a1a1a1a1/b1b1b1b1", mem[24], mem[25]);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] wr, rr, r2; logic [DW-1:0] d, d2; int lw, lr, l2;
    do_write(0, 16'h0004, 32'hAAAA5555, 4'hF, wr, lw);
    fork
      do_write(0, 16'h0004, 32'h00000001, 4'hF, wr, lw);
      do_read(1, 16'h0004, d, rr, lr);
    join
    checks++;
    if (d !== 32'hAAAA5555 && d !== 32'h00000001) begin
      errors++; $display("FAIL concurrent_rdata: got %h required aaaa5555 or 00000001", d);
    end
    checks++; if (wr !== 2'b00 || rr !== 2'b00) begin errors++; $display("FAIL concurrent_resps: got %b/%b required 00/00", wr, rr); end
    checks++; if (lw != 1 || lr != 1) begin errors++; $display("FAIL concurrent_grant_latency: got %0d/%0d required 1/1", lw, lr); end
    do_read(0, 16'h0004, d2, r2, l2);
    checks++; if (d2 !== 32'h00000001) begin errors++; $display("FAIL concurrent_readback: got %h required 00000001", d2); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; int lat; int av0, wv0, wr0;
    av0 = m_awv_hi; wv0 = m_wv_hi; wr0 = ram_writes;
    aw_delay = 5;
    do_write(0, 16'h0030, 32'h0BADCAFE, 4'hF, r, lat);
    aw_delay = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (m_awv_hi - av0 != 6) begin errors++; $display("FAIL bp_m_awvalid_cycles: got %0d required 6", m_awv_hi - av0); end
    checks++; if (m_wv_hi - wv0 != 1) begin errors++; $display("FAIL bp_m_wvalid_cycles: got %0d required 1", m_wv_hi - wv0); end
    checks++; if (ram_writes - wr0 != 1) begin errors++; $display("FAIL bp_write_count: got %0d required 1", ram_writes - wr0); end
    checks++; if (r !== 2'b00 || mem[12] !== 32'h0BADCAFE) begin errors++; $display("FAIL bp_result: got %b/%h required 00/0badcafe", r, mem[12]); end
  endtask

  task automatic test_rready_hold();
    logic [1:0] r; logic [DW-1:0] d; int lat, n, stable;
    do_write(1, 16'h0020, 32'h12345678, 4'hF, r, lat);
    do_write(1, 16'h0024, 32'hCAFEF00D, 4'hF, r, lat);
    araddr[1] = 16'h0020; arvalid[1] = 1'b1; rready[1] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready[1] && n < 50);
    @(posedge clk); #1; arvalid[1] = 1'b0;
    n = 0;
    while (!rvalid[1] && n < 50) begin @(posedge clk); #1; n++; end
    araddr[0] = 16'h0024; arvalid[0] = 1'b1;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (rvalid[1] && rdata[1] === 32'h12345678 && !arready[0]) stable++;
      @(posedge clk); #1;
    end
    checks++; if (stable != 10) begin errors++; $display("FAIL hold_stable_cycles: got %0d required 10", stable); end
    rready[1] = 1'b1;
    @(posedge clk); #1;
    rready[1] = 1'b0;
    checks++; if (rvalid[1] !== 1'b0) begin errors++; $display("FAIL hold_rvalid_drop: got %b required 0", rvalid[1]); end
    do_read(0, 16'h0024, d, r, lat);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_s0_read_after: got %h required cafef00d", d); end
  endtask

  task automatic test_partial();
    logic [1:0] r; int lat; int a0;
    a0 = awr_hi[0];
    awaddr[0] = 16'h0050; awvalid[0] = 1'b1; wvalid[0] = 1'b0;
    do_write(1, 16'h0054, 32'h55AA55AA, 4'hF, r, lat);
    awvalid[0] = 1'b0;
    checks++; if (awr_hi[0] - a0 != 0) begin errors++; $display("FAIL partial_no_grant: got %0d required 0", awr_hi[0] - a0); end
    checks++; if (r !== 2'b00 || lat != 1) begin errors++; $display("FAIL partial_other_port: got %b lat %0d required 00 lat 1", r, lat); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [DW-1:0] d; int lat, n, bv0;
    aw_delay = 5;
    awaddr[0] = 16'h0040; wdata[0] = 32'hFFFF0000; wstrb[0] = 4'hF; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready[0] && n < 50);
    @(posedge clk); #1; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_if.awvalid !== 1'b1) begin errors++; $display("FAIL midrst_in_fwd: got %b required 1", m_if.awvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
         awready[0], wready[0], bvalid[0], arready[0], rvalid[0]} !== 10'b0) begin
      errors++; $display("FAIL midrst_outputs_clear: got %b required 0",
        {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready,
         awready[0], wready[0], bvalid[0], arready[0], rvalid[0]});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; aw_delay = 0; bv0 = bv_hi[0];
    repeat (20) @(posedge clk); #1;
    checks++; if (bv_hi[0] - bv0 != 0) begin errors++; $display("FAIL midrst_no_bvalid: got %0d required 0", bv_hi[0] - bv0); end
    do_write(0, 16'h0044, 32'h5A5A5A5A, 4'hF, r, lat);
    do_read(0, 16'h0044, d, r, lat);
    checks++; if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL midrst_next_write: got %h required 5a5a5a5a", d); end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      awaddr[p] = '0; wdata[p] = '0; wstrb[p] = '0; araddr[p] = '0;
      awvalid[p] = 1'b0; wvalid[p] = 1'b0; bready[p] = 1'b0; arvalid[p] = 1'b0; rready[p] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_tie();
    test_concurrent();
    test_backpressure();
    test_rready_hold();
    test_partial();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
